ltl_automata_prog: RTL

- Runtime-programmable homogeneous automaton for LTL trace monitoring.
- NUM_STE states, each with a per-symbol match table, a start type, an incoming-edge row and a report-mask bit, all written through a config port while the monitor is idle.
- Consumes one SYMBOL_W-bit trace symbol per valid cycle and produces registered report vectors, a saturating report count and a capture of the first report's symbol index.
- Replaces the per-property hard-wired cluster automata in the monitor hierarchy: one instance can be reloaded for any cluster.

---
 rtl/ltl_automata_prog_if.sv | 36 +++
 rtl/ltl_automata_prog.sv | 92 +++++++++
 2 files changed

// File: rtl/ltl_automata_prog_if.sv
// ltl_automata_prog_if: run/trace/config/report bundle for the programmable LTL automaton
interface ltl_automata_prog_if #(
    parameter int NUM_STE = 9,
    parameter int SYMBOL_W = 8,
    parameter int CNT_W = 16
) ();
    localparam int IDX_W = $clog2(NUM_STE);
    localparam int ADDR_W = SYMBOL_W > IDX_W ? SYMBOL_W : IDX_W;
    logic run;
    logic flush;
    logic sym_valid;
    logic [SYMBOL_W-1:0] symbols;
    logic cfg_we;
    logic [1:0] cfg_sel;
    logic [IDX_W-1:0] cfg_ste;
    logic [ADDR_W-1:0] cfg_addr;
    logic [1:0] cfg_data;
    logic cfg_err;
    logic [NUM_STE-1:0] active_vec;
    logic [NUM_STE-1:0] report_vec;
    logic report_any;
    logic first_rpt_valid;
    logic [CNT_W-1:0] first_rpt_idx;
    logic [CNT_W-1:0] report_count;
    logic [CNT_W-1:0] sym_count;
    modport master (
        output run, flush, sym_valid, symbols, cfg_we, cfg_sel, cfg_ste, cfg_addr, cfg_data,
        input cfg_err, active_vec, report_vec, report_any, first_rpt_valid, first_rpt_idx,
        report_count, sym_count
    );
    modport slave (
        input run, flush, sym_valid, symbols, cfg_we, cfg_sel, cfg_ste, cfg_addr, cfg_data,
        output cfg_err, active_vec, report_vec, report_any, first_rpt_valid, first_rpt_idx,
        report_count, sym_count
    );
endinterface

// File: rtl/ltl_automata_prog.sv
// ltl_automata_prog: runtime-programmable homogeneous automaton for LTL trace monitoring
module ltl_automata_prog #(
    parameter int NUM_STE = 9,
    parameter int SYMBOL_W = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    ltl_automata_prog_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_STE);
    localparam int ADDR_W = SYMBOL_W > IDX_W ? SYMBOL_W : IDX_W;
    localparam int NSYM = 1 << SYMBOL_W;
    localparam logic [IDX_W:0] ste_lim = (IDX_W + 1)'(NUM_STE);
    localparam logic [ADDR_W:0] addr_lim = (ADDR_W + 1)'(NUM_STE);
    localparam logic [CNT_W-1:0] cnt_one = 1;

    logic [NSYM-1:0] match [NUM_STE];
    logic [NUM_STE-1:0] edges [NUM_STE];
    logic [NUM_STE-1:0] col [NUM_STE];
    logic [1:0] st [NUM_STE];
    logic [NUM_STE-1:0] mask, active, nxt, nxt_rep;
    logic sod, cfg_err, frv;
    logic [CNT_W-1:0] fri, rc, sc;
    logic ste_ok, addr_ok, cfg_ok, consume;

    assign ste_ok = {1'b0, bus.cfg_ste} < ste_lim;
    assign addr_ok = bus.cfg_sel != 2'd1 || {1'b0, bus.cfg_addr} < addr_lim;
    assign cfg_ok = bus.cfg_we && !bus.run && ste_ok && addr_ok;
    assign consume = bus.run && bus.sym_valid && !bus.flush;

    // col[i][j]: source j is active and has an edge into i
    for (genvar i = 0; i < NUM_STE; i++) begin : g_ste
        for (genvar j = 0; j < NUM_STE; j++) begin : g_src
            assign col[i][j] = active[j] & edges[j][i];
        end
        assign nxt[i] = (st[i] == 2'd2 || (st[i] == 2'd1 && sod) || |col[i]) && match[i][bus.symbols];
    end
    assign nxt_rep = nxt & mask;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STE; i++) begin
                match[i] <= '0;
                edges[i] <= '0;
                st[i] <= '0;
            end
            mask <= '0;
            active <= '0;
            sod <= 1'b1;
            cfg_err <= 1'b0;
            frv <= 1'b0;
            fri <= '0;
            rc <= '0;
            sc <= '0;
        end else begin
            cfg_err <= bus.cfg_we && !cfg_ok;
            if (cfg_ok) begin
                if (bus.cfg_sel == 2'd0) match[bus.cfg_ste][bus.cfg_addr[SYMBOL_W-1:0]] <= bus.cfg_data[0];
                if (bus.cfg_sel == 2'd1) edges[bus.cfg_addr[IDX_W-1:0]][bus.cfg_ste] <= bus.cfg_data[0];
                if (bus.cfg_sel == 2'd2) st[bus.cfg_ste] <= bus.cfg_data;
                if (bus.cfg_sel == 2'd3) mask[bus.cfg_ste] <= bus.cfg_data[0];
            end
            if (bus.flush) begin
                active <= '0;
                sod <= 1'b1;
                frv <= 1'b0;
                fri <= '0;
            end else if (consume) begin
                active <= nxt;
                sod <= 1'b0;
                sc <= &sc ? sc : sc + cnt_one;
                if (|nxt_rep) begin
                    rc <= &rc ? rc : rc + cnt_one;
                    if (!frv) begin
                        frv <= 1'b1;
                        fri <= sc;
                    end
                end
            end
        end
    end

    assign bus.cfg_err = cfg_err;
    assign bus.active_vec = active;
    assign bus.report_vec = active & mask;
    assign bus.report_any = |(active & mask);
    assign bus.first_rpt_valid = frv;
    assign bus.first_rpt_idx = fri;
    assign bus.report_count = rc;
    assign bus.sym_count = sc;
endmodule
